toggle_rx: RTL and testbench



---
 rtl/toggle_rx.sv | 149 ++++++++++++++
 tb/tb_toggle_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_rx.sv
// toggle_rx: receiving end of the toggle-handshake link.
// Synchronises the sender's request level and captures one word per level change
// into a small FIFO. It returns an acknowledge toggle per accepted word and presents
// the stored words on a valid/ready port. A full FIFO withholds the acknowledge.
module toggle_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_tgl,
  input  logic [WIDTH-1:0]         req_data,
  output logic                     ack_tgl,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     event_pulse,
  output logic                     stalled,
  output logic [15:0]              evt_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SYNC-1:0]   r_sync;
  logic              r_last_lvl;
  logic              r_ack_tgl;
  logic              r_event_pulse;
  logic [15:0]       r_evt_count;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  logic              w_req_s;
  logic              w_pending;
  logic              w_full;
  logic              w_accept;
  logic              w_pop;

  assign w_req_s   = r_sync[SYNC-1];
  assign w_pending = (w_req_s != r_last_lvl);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = out_valid && out_ready;

  // Synchroniser chain for the asynchronous-origin request level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC-2:0], req_tgl};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and accept decision; a full FIFO blocks the accept even on a pop edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          if (w_full) begin
            w_state_nxt = ST_STALL;
          end else begin
            w_accept = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (!w_full) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake bookkeeping: remember accepted level, toggle ack, pulse and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lvl    <= 1'b0;
      r_ack_tgl     <= 1'b0;
      r_event_pulse <= 1'b0;
      r_evt_count   <= '0;
    end else begin
      r_event_pulse <= w_accept;
      if (w_accept) begin
        r_last_lvl  <= w_req_s;
        r_ack_tgl   <= ~r_ack_tgl;
        r_evt_count <= r_evt_count + 16'd1;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= req_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign ack_tgl     = r_ack_tgl;
  assign out_valid   = (r_level != '0);
  assign out_data    = r_mem[r_rd_ptr];
  assign event_pulse = r_event_pulse;
  assign stalled     = (r_state == ST_STALL);
  assign evt_count   = r_evt_count;
  assign level       = r_level;

endmodule

// File: tb/tb_toggle_rx.sv
// tb_toggle_rx: directed bench for toggle_rx with default parameters
// (WIDTH=8, DEPTH=4, SYNC=2).
module tb_toggle_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_tgl;
  logic [7:0]  req_data;
  logic        ack_tgl;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        event_pulse;
  logic        stalled;
  logic [15:0] evt_count;
  logic [2:0]  level;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  rx_q[$];
  int          max_level;
  int          edges;

  toggle_rx #(.WIDTH(8), .DEPTH(4), .SYNC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_tgl     (req_tgl),
    .req_data    (req_data),
    .ack_tgl     (ack_tgl),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .event_pulse (event_pulse),
    .stalled     (stalled),
    .evt_count   (evt_count),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; record any word handed over on that edge.
  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) rx_q.push_back(out_data);
    if (int'(level) > max_level) max_level = int'(level);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_tgl = 1'b0;
    tick();
    rst     = 1'b0;
    rx_q.delete();
    max_level = 0;
  endtask

  // One sender transfer: flip request, wait (bounded) for the ack to match.
  task automatic do_xfer(input logic [7:0] d, output int n);
    req_data = d;
    req_tgl  = ~req_tgl;
    n = 0;
    while (ack_tgl !== req_tgl && n < 40) begin
      tick();
      n++;
    end
    if (ack_tgl !== req_tgl) check_eq("ack_timeout", {31'd0, ack_tgl}, {31'd0, req_tgl});
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check_eq($sformatf("%s_word%0d", tag, i),
               (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD, {24'd0, exp[i]});
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_tgl   = 1'b0;
    req_data  = 8'h00;
    out_ready = 1'b0;
    max_level = 0;
    #1;

    // Reset state
    do_reset();
    check_eq("rst_ack",    ack_tgl,     0);
    check_eq("rst_valid",  out_valid,   0);
    check_eq("rst_data",   out_data,    0);
    check_eq("rst_pulse",  event_pulse, 0);
    check_eq("rst_stall",  stalled,     0);
    check_eq("rst_count",  evt_count,   0);
    check_eq("rst_level",  level,       0);

    // Single transfer: ack flips after the third edge
    do_xfer(8'hA5, edges);
    check_eq("t1_latency", edges,       3);
    check_eq("t1_ack",     ack_tgl,     1);
    check_eq("t1_pulse",   event_pulse, 1);
    check_eq("t1_valid",   out_valid,   1);
    check_eq("t1_data",    out_data,    8'hA5);
    check_eq("t1_count",   evt_count,   1);
    check_eq("t1_level",   level,       1);
    tick();
    check_eq("t1_pulse_end", event_pulse, 0);

    // Four back-to-back transfers with a ready consumer
    do_reset();
    out_ready = 1'b1;
    do_xfer(8'h11, edges); check_eq("t2_lat0", edges, 3);
    do_xfer(8'h22, edges); check_eq("t2_lat1", edges, 3);
    do_xfer(8'h33, edges); check_eq("t2_lat2", edges, 3);
    do_xfer(8'h44, edges); check_eq("t2_lat3", edges, 3);
    tick(); tick();
    check_rx("t2", '{8'h11, 8'h22, 8'h33, 8'h44});
    check_eq("t2_maxlevel", max_level, 1);
    check_eq("t2_count",    evt_count, 4);
    check_eq("t2_level",    level,     0);
    out_ready = 1'b0;

    // Fill, stall, release one slot
    do_reset();
    do_xfer(8'h01, edges);
    do_xfer(8'h02, edges);
    do_xfer(8'h03, edges);
    do_xfer(8'h04, edges);
    check_eq("t3_level_full", level, 4);
    req_data = 8'h05;
    req_tgl  = ~req_tgl;
    tick(); tick(); tick();
    check_eq("t3_stalled",  stalled, 1);
    check_eq("t3_ack_held", ack_tgl, 0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("t3_stalled_hold", stalled, 1);
    check_eq("t3_ack_hold",     ack_tgl, 0);
    check_eq("t3_level_hold",   level,   4);
    check_eq("t3_data_hold",    out_data, 8'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t3_pop_level", level,    3);
    check_eq("t3_pop_ack",   ack_tgl,  0);
    check_eq("t3_pop_data",  out_data, 8'h02);
    tick();
    check_eq("t3_acc_ack",   ack_tgl,     1);
    check_eq("t3_acc_level", level,       4);
    check_eq("t3_acc_stall", stalled,     0);
    check_eq("t3_acc_pulse", event_pulse, 1);
    check_eq("t3_count",     evt_count,   5);

    // Simultaneous push and pop at level 2
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check_eq("t4_level_pre", level, 2);
    req_data = 8'h06;
    req_tgl  = ~req_tgl;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t4_level_same", level,       2);
    check_eq("t4_ack",        ack_tgl,     0);
    check_eq("t4_pulse",      event_pulse, 1);
    check_eq("t4_head",       out_data,    8'h05);
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    check_rx("t34", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    check_eq("t4_level_end", level, 0);

    // Reset mid-operation with a pending request
    do_reset();
    do_xfer(8'hC1, edges);
    do_xfer(8'hC2, edges);
    do_xfer(8'hC3, edges);
    check_eq("t5_level3", level, 3);
    req_data = 8'hC4;
    req_tgl  = ~req_tgl;
    tick();
    rst     = 1'b1;
    req_tgl = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_level", level,     0);
    check_eq("t5_ack",   ack_tgl,   0);
    check_eq("t5_count", evt_count, 0);
    check_eq("t5_stall", stalled,   0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("t5_quiet_level", level,   0);
    check_eq("t5_quiet_ack",   ack_tgl, 0);

    // Counter wrap via preload
    do_reset();
    force dut.r_evt_count = 16'hFFFF;
    tick();
    release dut.r_evt_count;
    tick();
    check_eq("t6_preload", evt_count, 16'hFFFF);
    do_xfer(8'h77, edges);
    check_eq("t6_wrap",     evt_count, 16'h0000);
    check_eq("t6_wrap_dat", out_data,  8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
